read_data_router: RTL
=====================

# read_data_router

Parametrised, pipelined successor to the combinational memory read multiplexer. Routes read data from `NUM_SRC` memory banks to a single `ReadData` output, steering by a selector captured at request time and delayed to match the banks' synchronous read latency. It adds a response valid strobe, out-of-range detection, an outstanding-read count and an error counter. It sits between the data memories (RAM/ROM/peripheral banks) and the processor's load writeback path.

## Interface
Parameters:
- `NUM_SRC`, 3: number of read sources; legal range is 2 to 16.
- `DATA_W`, 32: data width.
- `SEL_W`, `$clog2(NUM_SRC)`: selector width; derived, not overridden.
- `READ_LAT`, 1: source read latency in cycles; minimum 1.
- `ERR_CNT_W`, 16: error counter width.

Ports:
- Clocking and reset. One clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock.
  - `reset`  in  1  synchronous, active-high reset.
- Request side.
  - `ReqValid`  in  1  a read was issued to the banks this cycle.
  - `ReqSel`  in  `SEL_W`  bank selected by that read.
- Source data.
  - `ReadDataIn`  in  `NUM_SRC`×`DATA_W`  packed; element i is bank i's read data.
- Response side.
  - `RspValid`  out  1  one-cycle strobe: `ReadData` holds a new response.
  - `ReadData`  out  `DATA_W`  routed data; registered.
  - `RspErr`  out  1  qualifies `RspValid`; high when the selector was out of range.
- Status.
  - `Outstanding`  out  `$clog2(READ_LAT+2)`  number of issued reads not yet responded.
  - `ErrCount`  out  `ERR_CNT_W`  saturating count of out-of-range responses.

## Operation
- **Tag pipeline.** A `READ_LAT`-stage shift register of {valid, sel} entries.
  - Stage 1 loads {`ReqValid`, `ReqSel`} every edge.
  - Stage j loads stage j-1 every edge.
  - There is no stall; the block accepts one request per cycle, back-to-back.
- **Output register.** Loads at each edge where the last stage is valid:
  - `sel` < `NUM_SRC`: `ReadData` ← `ReadDataIn[sel]`, `RspErr` ← 0.
  - `sel` ≥ `NUM_SRC` (for example, 3 with `NUM_SRC`=3): `ReadData` ← 0, `RspErr` ← 1, and `ErrCount` increments.
  - `RspValid` ← last-stage valid.
- **Data hold.** When `RspValid` is low, `ReadData` holds the last response (it does not go to 0). `RspErr` is forced to 0 when `RspValid` is low.
- **Outstanding counter.**
  - Increments on `ReqValid`.
  - Decrements on each cycle in which `RspValid` is high.
  - When both occur in the same cycle, it is unchanged.
  - Its maximum is `READ_LAT`+1, which needs no overflow handling.
- **ErrCount.** Saturates at all-ones and never wraps.
- **Reset.** Clears all pipeline valids, `RspValid`, `RspErr`, `ReadData` (to 0), `Outstanding` and `ErrCount`. In-flight reads are dropped silently and produce no late response.

## Timing
- Request sampled at edge k → `RspValid` is high for the single cycle after edge k+`READ_LAT`.
- `ReadDataIn` for that request is sampled at edge k+`READ_LAT`. This matches a bank that registers its address at edge k with `READ_LAT` cycles of read latency.
- `ReqSel` only matters when `ReqValid` is high; it is ignored otherwise.
- Reset asserted at edge r → all outputs are 0 after edge r. A request presented in the same cycle as reset is discarded.
- The only combinational paths are register → output; there is no input-to-output combinational path.

## Structure
- Package `read_router_pkg` holds:
  - default constants `DEF_NUM_SRC`, `DEF_DATA_W`, `DEF_READ_LAT`;
  - the typedef `rd_tag_t` (packed struct {valid, sel}), with sel sized to the maximum `SEL_W` of 4.
- Sub-module `read_tag_pipe`: the parametrised `READ_LAT`-deep shift register of `rd_tag_t` with synchronous clear. The top level instantiates it and holds the mux, output register and counters.

## Test plan
- **Basic routing.** Defaults; a single `ReqValid` with `ReqSel`=1, bank 1 = 0xDEADBEEF → `RspValid` high for 1 cycle, exactly 2 edges later, with `ReadData`=0xDEADBEEF and `RspErr`=0; `ReadData` then holds 0xDEADBEEF.
- **Back-to-back streaming.** `READ_LAT`=3, `NUM_SRC`=4; sels 0,1,2,3 on consecutive cycles, each bank returning its index → responses 0,1,2,3 on 4 consecutive cycles; `Outstanding` peaks at 4 and returns to 0.
- **Out of range.** `ReqSel`=3 with `NUM_SRC`=3 → `RspValid`=1, `RspErr`=1, `ReadData`=0, `ErrCount`=1; the following valid read has `RspErr`=0.
- **Counter saturation.** `ERR_CNT_W`=2; 5 out-of-range reads → `ErrCount` goes 1, 2, 3, 3, 3.
- **Reset mid-flight.** `READ_LAT`=2; issue 2 reads, then assert reset for 1 cycle → no `RspValid` ever appears for them; `Outstanding`=0 and `ReadData`=0 after the reset edge.
- **Simultaneous request and response.** Continuous stream of requests → `Outstanding` stays constant at `READ_LAT`+1 in steady state.

Source files
------------

// File: rtl/read_data_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : read_router_pkg
// Description : Shared constants and the read tag type for read_data_router.
// Revision    : 1.0 - initial release
// ============================================================================
package read_router_pkg;

  localparam int DEF_NUM_SRC   = 3;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_READ_LAT  = 1;
  localparam int DEF_ERR_CNT_W = 16;

  // Widest selector needed for the largest legal source count (16).
  localparam int c_max_sel_w = 4;

  typedef struct packed {
    logic                   valid;
    logic [c_max_sel_w-1:0] sel;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/read_data_router_if.sv
`default_nettype none
// ============================================================================
// Module      : read_data_router_if
// Description : Request, bank data, response and status bundle of the router.
// Revision    : 1.0 - initial release
// ============================================================================
interface read_data_router_if
  import read_router_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int OUT_W     = $clog2(READ_LAT + 2)
);

  logic                             ReqValid;
  logic [SEL_W-1:0]                 ReqSel;
  logic [NUM_SRC-1:0][DATA_W-1:0]   ReadDataIn;
  logic                             RspValid;
  logic [DATA_W-1:0]                ReadData;
  logic                             RspErr;
  logic [OUT_W-1:0]                 Outstanding;
  logic [ERR_CNT_W-1:0]             ErrCount;

  modport master (
    output ReqValid, ReqSel, ReadDataIn,
    input  RspValid, ReadData, RspErr, Outstanding, ErrCount
  );

  modport slave (
    input  ReqValid, ReqSel, ReadDataIn,
    output RspValid, ReadData, RspErr, Outstanding, ErrCount
  );

endinterface
`default_nettype wire

// File: rtl/read_data_router_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : read_tag_pipe
// Description : DEPTH-stage shift register of read tags with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module read_tag_pipe
  import read_router_pkg::*;
#(
  parameter int DEPTH = DEF_READ_LAT
) (
  input  wire logic clk,
  input  wire logic reset,
  input  rd_tag_t   i_tag,
  output rd_tag_t   o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_stage[j] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int j = 1; j < DEPTH; j++) begin
        r_stage[j] <= r_stage[j-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/read_data_router.sv
`default_nettype none
// ============================================================================
// Module      : read_data_router
// Description : Latency-matched read data mux with response strobe, range
//               error detection, outstanding-read and error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module read_data_router
  import read_router_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input wire logic          clk,
  input wire logic          reset,
  read_data_router_if.slave bus
);

  localparam int c_out_w = $clog2(READ_LAT + 2);
  localparam logic [c_max_sel_w:0]   c_num_src = (c_max_sel_w + 1)'(NUM_SRC);
  localparam logic [c_out_w-1:0]     c_out_one = c_out_w'(1);
  localparam logic [ERR_CNT_W-1:0]   c_err_one = ERR_CNT_W'(1);

  rd_tag_t             w_req_tag;
  rd_tag_t             w_last_tag;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_sel_data;

  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_read_data;
  logic [c_out_w-1:0]  r_outstanding;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_comb begin
    w_req_tag                = '0;
    w_req_tag.valid          = bus.ReqValid;
    w_req_tag.sel[SEL_W-1:0] = bus.ReqSel;
  end

  read_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_req_tag),
    .o_tag (w_last_tag)
  );

  // Compare on the full 4-bit tag so codes beyond NUM_SRC are caught.
  assign w_in_range = ({1'b0, w_last_tag.sel} < c_num_src);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_last_tag.sel == c_max_sel_w'(i)) begin
        w_sel_data = bus.ReadDataIn[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_read_data <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_rsp_valid <= w_last_tag.valid;
      r_rsp_err   <= w_last_tag.valid & ~w_in_range;
      if (w_last_tag.valid) begin
        r_read_data <= w_in_range ? w_sel_data : '0;
        if (!w_in_range && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + c_err_one;
        end
      end
    end
  end

  // A response retires in the cycle its strobe is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else begin
      case ({bus.ReqValid, r_rsp_valid})
        2'b10:   r_outstanding <= r_outstanding + c_out_one;
        2'b01:   r_outstanding <= r_outstanding - c_out_one;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign bus.RspValid    = r_rsp_valid;
  assign bus.RspErr      = r_rsp_err;
  assign bus.ReadData    = r_read_data;
  assign bus.Outstanding = r_outstanding;
  assign bus.ErrCount    = r_err_cnt;

endmodule
`default_nettype wire
